ysyx_25020047_mem_arb: RTL and testbench

- Two-master, one-slave memory arbiter and sequencer for the multi-cycle NPC core.
- IFU (read-only fetch) and LSU (load/store) share a single memory port.
- Grants round-robin, registers the winning request, drives the slave handshake, waits for the response and routes it back to the owner.
- A watchdog returns an error response if the slave never answers.

---
 rtl/ysyx_25020047_mem_arb_if.sv | 50 +++++
 rtl/ysyx_25020047_mem_arb.sv | 123 ++++++++++++
 tb/tb_ysyx_25020047_mem_arb.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_mem_arb_if.sv
// Bus bundle between the IFU/LSU requesters, the shared-port arbiter and the memory slave.
// The master modport is the arbiter itself; the slave modport is everything around it.
interface ysyx_25020047_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_rdata;
  logic                  ifu_resp_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25020047_mem_arb.sv
// Round-robin IFU/LSU arbiter sharing one memory port: latches the winner's request,
// runs the slave handshake and routes the response (or a watchdog error) back to the owner.
module ysyx_25020047_mem_arb #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic rst_n,
  ysyx_25020047_mem_arb_if.master bus
);

  localparam int            MASK_W  = DATA_W / 8;
  localparam logic [15:0]   TO_CNT  = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  state_t      state_next;
  logic        last_lsu;
  logic        owner_lsu;
  logic [15:0] cnt;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        accept;
  logic        done;
  logic        timeout;

  // Both valid: the master that did not win last time goes first.
  always_comb begin
    grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu);
    grant_lsu = bus.lsu_req_valid && !grant_ifu;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ifu || grant_lsu) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (cnt == TO_CNT) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else if (bus.mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A response landing on the last allowed cycle still wins over the watchdog.
        if (bus.mem_resp_valid) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (cnt == TO_CNT) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ifu_req_ready = (state == IDLE) && grant_ifu;
    bus.lsu_req_ready = (state == IDLE) && grant_lsu;
    bus.mem_req_valid = (state == REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_lsu           <= 1'b1;
      owner_lsu          <= 1'b0;
      cnt                <= '0;
      bus.mem_addr       <= '0;
      bus.mem_wen        <= 1'b0;
      bus.mem_wdata      <= '0;
      bus.mem_wmask      <= '0;
      bus.ifu_resp_valid <= 1'b0;
      bus.ifu_rdata      <= '0;
      bus.ifu_resp_err   <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;
      bus.lsu_rdata      <= '0;
      bus.lsu_resp_err   <= 1'b0;
    end else begin
      bus.ifu_resp_valid <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;
      if (accept) begin
        bus.mem_addr  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        bus.mem_wen   <= grant_lsu && bus.lsu_wen;
        bus.mem_wdata <= grant_lsu ? bus.lsu_wdata : '0;
        bus.mem_wmask <= grant_lsu ? bus.lsu_wmask : {MASK_W{1'b0}};
        owner_lsu     <= grant_lsu;
        last_lsu      <= grant_lsu;
        cnt           <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + 16'd1;
      end
      if (done || timeout) begin
        if (owner_lsu) begin
          bus.lsu_resp_valid <= 1'b1;
          bus.lsu_rdata      <= (done && !bus.mem_wen) ? bus.mem_rdata : '0;
          bus.lsu_resp_err   <= timeout;
        end else begin
          bus.ifu_resp_valid <= 1'b1;
          bus.ifu_rdata      <= done ? bus.mem_rdata : '0;
          bus.ifu_resp_err   <= timeout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_arb.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios plus randomized transactions
// predicted from per-transaction slave delays against the watchdog limit.
module tb_ysyx_25020047_mem_arb;

  localparam int TO = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_25020047_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ysyx_25020047_mem_arb #(.TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mdl_last_lsu = 1'b1;

  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_last_lsu = 1'b1;
    @(negedge clk);
  endtask

  // One transaction: the slave holds ready low for r REQ cycles and answers d cycles after
  // accepting. The watchdog allows TO counted cycles, so a response whose count r+d exceeds
  // TO becomes an error pulse at TO+2 cycles after the grant, otherwise at r+d+2.
  task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                        input bit lwen, input logic [31:0] lwd, input logic [3:0] lwm,
                        input int r, input int d, input logic [31:0] rd, input string tag);
    bit          win_lsu;
    bit          err_exp;
    int          exp_k;
    int          kmax;
    int          req_last;
    logic [31:0] erd;
    logic [68:0] efld;
    logic [31:0] ardata;
    logic        aerr;
    if (iv && lv) win_lsu = !mdl_last_lsu;
    else          win_lsu = lv;
    err_exp  = (r + d) > TO;
    exp_k    = (err_exp ? TO : r + d) + 2;
    kmax     = ((exp_k > 1 + r + d) ? exp_k : 1 + r + d) + 1;
    req_last = 1 + ((r < TO) ? r : TO);
    erd      = (err_exp || (win_lsu && lwen)) ? 32'h0 : rd;
    efld     = win_lsu ? {la, lwen, lwd, lwm} : {ia, 1'b0, 32'h0, 4'h0};

    @(posedge clk); #1;
    bus.ifu_req_valid = iv;
    bus.ifu_addr      = ia;
    bus.lsu_req_valid = lv;
    bus.lsu_addr      = la;
    bus.lsu_wen       = lwen;
    bus.lsu_wdata     = lwd;
    bus.lsu_wmask     = lwm;
    @(negedge clk);
    n_vec++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== {iv && !win_lsu, win_lsu}) begin
      n_err++;
      $display("FAIL %s grant: ready ifu/lsu=%b%b expected %b%b", tag,
               bus.ifu_req_ready, bus.lsu_req_ready, iv && !win_lsu, win_lsu);
    end
    mdl_last_lsu = win_lsu;

    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk); #1;
      bus.ifu_req_valid  = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      bus.mem_req_ready  = (k - 1 == r);
      bus.mem_resp_valid = (k == 1 + r + d);
      bus.mem_rdata      = (k == 1 + r + d) ? rd : $urandom;
      @(negedge clk);
      n_vec++;
      if (bus.mem_req_valid !== (k <= req_last)) begin
        n_err++;
        $display("FAIL %s mem_req_valid k=%0d: got %b expected %b", tag, k,
                 bus.mem_req_valid, k <= req_last);
      end
      if (k <= req_last) begin
        n_vec++;
        if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== efld) begin
          n_err++;
          $display("FAIL %s mem fields k=%0d: got %h expected %h", tag, k,
                   {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, efld);
        end
      end
      n_vec++;
      if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !==
          {!win_lsu && k == exp_k, win_lsu && k == exp_k}) begin
        n_err++;
        $display("FAIL %s resp_valid k=%0d: ifu/lsu=%b%b expected pulse at k=%0d to %s", tag, k,
                 bus.ifu_resp_valid, bus.lsu_resp_valid, exp_k, win_lsu ? "lsu" : "ifu");
      end
      if (k == exp_k) begin
        ardata = win_lsu ? bus.lsu_rdata : bus.ifu_rdata;
        aerr   = win_lsu ? bus.lsu_resp_err : bus.ifu_resp_err;
        n_vec++;
        if ({ardata, aerr} !== {erd, err_exp}) begin
          n_err++;
          $display("FAIL %s resp data: rdata=%h err=%b expected rdata=%h err=%b", tag,
                   ardata, aerr, erd, err_exp);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset handshake: got %b expected 000",
               {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid});
    end
    n_vec++;
    if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== 69'h0) begin
      n_err++;
      $display("FAIL reset mem fields: got %h expected 0",
               {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask});
    end
    n_vec++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_resp_err,
         bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_resp_err} !== 68'h0) begin
      n_err++;
      $display("FAIL reset responses: got %h expected 0",
               {bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_resp_err,
                bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_resp_err});
    end
  endtask

  task automatic test_ifu_read();
    do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h0000_0413, "ifu_read");
  endtask

  task automatic test_alternation();
    apply_reset();
    do_txn(1, 1, 32'h8000_0010, 32'h8000_2000, 0, 32'h0, 4'h0, 0, 1, 32'h1111_1111, "alt1_ifu");
    do_txn(1, 1, 32'h8000_0014, 32'h8000_2004, 0, 32'h0, 4'h0, 1, 2, 32'h2222_2222, "alt2_lsu");
    do_txn(1, 1, 32'h8000_0018, 32'h8000_2008, 1, 32'h5A5A_5A5A, 4'hF, 0, 1, 32'h3333_3333,
           "alt3_ifu");
  endtask

  task automatic test_store_stall();
    do_txn(0, 1, 32'h0, 32'h8000_0101, 1, 32'h0000_AB00, 4'h2, 3, 2, 32'hDEAD_BEEF, "store");
    do_txn(0, 1, 32'h0, 32'h8000_0200, 1, 32'h1234_5678, 4'h0, 1, 1, 32'hCAFE_F00D,
           "store_mask0");
  endtask

  task automatic test_timeout();
    do_txn(0, 1, 32'h0, 32'h8000_0300, 0, 32'h0, 4'h0, 0, 20, 32'hBAD0_0001, "to_wait");
    do_txn(1, 0, 32'h8000_0400, 32'h0, 0, 32'h0, 4'h0, 12, 1, 32'hBAD0_0002, "to_req");
    do_txn(0, 1, 32'h0, 32'h8000_0500, 0, 32'h0, 4'h0, 2, TO - 2, 32'h600D_0003, "to_edge_ok");
    do_txn(0, 1, 32'h0, 32'h8000_0600, 0, 32'h0, 4'h0, 2, TO - 1, 32'hBAD0_0004, "to_edge_err");
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_0700;
    bus.lsu_wen       = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.lsu_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_wait accept: lsu_req_ready=%b expected 1", bus.lsu_req_ready);
    end
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h7777_7777;
    rst_n              = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait in_wait: mem_req_valid=%b expected 0", bus.mem_req_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b0;
    mdl_last_lsu = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid, bus.lsu_rdata,
           bus.mem_addr} !== 67'h0) begin
        n_err++;
        $display("FAIL rst_wait outputs cycle %0d: got %h expected 0", k,
                 {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid, bus.lsu_rdata,
                  bus.mem_addr});
      end
      if (k == 0) begin
        @(posedge clk); #1;
      end
    end
    do_txn(1, 0, 32'h8000_0800, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h0000_0013, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1;
    logic [31:0] d2;
    d1 = 32'hA1A1_0001;
    d2 = 32'hB2B2_0002;
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    @(negedge clk);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = d1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h8000_1004;
    @(negedge clk);
    n_vec++;
    if ({bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_req_ready} !== {1'b1, d1, 1'b1}) begin
      n_err++;
      $display("FAIL b2b first: valid/rdata/ready=%b/%h/%b expected 1/%h/1",
               bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_req_ready, d1);
    end
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.lsu_resp_valid} !== {1'b1, 32'h8000_1004, 1'b0}) begin
      n_err++;
      $display("FAIL b2b second req: valid/addr/resp=%b/%h/%b expected 1/80001004/0",
               bus.mem_req_valid, bus.mem_addr, bus.lsu_resp_valid);
    end
    @(posedge clk); #1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = d2;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_resp_err} !== {1'b1, d2, 1'b0}) begin
      n_err++;
      $display("FAIL b2b second resp: valid/rdata/err=%b/%h/%b expected 1/%h/0",
               bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_resp_err, d2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({bus.lsu_resp_valid, bus.lsu_rdata} !== {1'b0, d2}) begin
      n_err++;
      $display("FAIL b2b hold: valid/rdata=%b/%h expected 0/%h",
               bus.lsu_resp_valid, bus.lsu_rdata, d2);
    end
    mdl_last_lsu = 1'b1;
    idle_inputs();
  endtask

  task automatic test_random();
    int sel;
    int r;
    int d;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      r   = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 12) : $urandom_range(0, 4);
      d   = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(1, 4);
      do_txn(sel != 1, sel != 0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
             4'($urandom), r, d, $urandom, "random");
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ifu_read();
    test_alternation();
    test_store_stall();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
